// File: rtl/regfile_scoreboard.sv
// 32-entry register file with writeback/status bypass and a busy-bit scoreboard
// that stalls decode while a source operand's producer is still outstanding.
module regfile_scoreboard #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [4:0]      read_a,
    input  logic [4:0]      read_b,
    output logic [DW-1:0]   data_a,
    output logic [DW-1:0]   data_b,
    input  logic            wb_en,
    input  logic [4:0]      wb_reg,
    input  logic [DW-1:0]   wb_data,
    input  logic            st_en,
    input  logic [DW-1:0]   st_data,
    input  logic            issue_en,
    input  logic [4:0]      issue_reg,
    output logic            stall,
    output logic [NREG-1:0] busy
);

    localparam logic [4:0] STATUS_REG = 5'd30;

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wb_live;
    logic            clr_a;
    logic            clr_b;

    assign wb_live = wb_en && (wb_reg != 5'd0);

    // Status bypass beats writeback bypass; r0 is hardwired to zero.
    always_comb begin
        data_a = '0;
        if (read_a != 5'd0) begin
            if (st_en && read_a == STATUS_REG)
                data_a = st_data;
            else if (wb_en && wb_reg == read_a)
                data_a = wb_data;
            else
                data_a = regs_q[read_a];
        end
    end

    always_comb begin
        data_b = '0;
        if (read_b != 5'd0) begin
            if (st_en && read_b == STATUS_REG)
                data_b = st_data;
            else if (wb_en && wb_reg == read_b)
                data_b = wb_data;
            else
                data_b = regs_q[read_b];
        end
    end

    // A source being cleared this cycle is already bypassed, so it does not stall.
    always_comb begin
        clr_a = (wb_live && wb_reg == read_a) || (st_en && read_a == STATUS_REG);
        clr_b = (wb_live && wb_reg == read_b) || (st_en && read_b == STATUS_REG);
        stall = (busy_q[read_a] && !clr_a) || (busy_q[read_b] && !clr_b);
    end

    // Set is applied after clear so a newer producer on the same index stays pending.
    always_comb begin
        busy_d = busy_q;
        if (wb_live)
            busy_d[wb_reg] = 1'b0;
        if (st_en)
            busy_d[STATUS_REG] = 1'b0;
        if (issue_en && !stall && issue_reg != 5'd0)
            busy_d[issue_reg] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else begin
            if (wb_live)
                regs_q[wb_reg] <= wb_data;
            if (st_en)
                regs_q[STATUS_REG] <= st_data;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a cycle table of stimulus with expected outputs,
// followed by a randomised write/read-back phase checked against a memory model.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int EW = 2 * DW + 1 + 32;
    localparam int NV = 26;

    logic          clock;
    logic          reset_n;
    logic [4:0]    read_a, read_b;
    logic [DW-1:0] data_a, data_b;
    logic          wb_en;
    logic [4:0]    wb_reg;
    logic [DW-1:0] wb_data;
    logic          st_en;
    logic [DW-1:0] st_data;
    logic          issue_en;
    logic [4:0]    issue_reg;
    logic          stall;
    logic [31:0]   busy;

    typedef struct {
        logic          rst;
        logic          wb_en;
        logic [4:0]    wb_reg;
        logic [DW-1:0] wb_data;
        logic          st_en;
        logic [DW-1:0] st_data;
        logic          issue_en;
        logic [4:0]    issue_reg;
        logic [4:0]    ra;
        logic [4:0]    rb;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic          es;
        logic [31:0]   ebusy;
    } vec_t;

    vec_t          vecs [NV];
    logic [EW-1:0] exp_q [$];
    logic [DW-1:0] model [32];
    int            n_checks = 0;
    int            n_fail   = 0;

    regfile_scoreboard #(.NREG(32), .DW(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .read_a    (read_a),
        .read_b    (read_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .st_en     (st_en),
        .st_data   (st_data),
        .issue_en  (issue_en),
        .issue_reg (issue_reg),
        .stall     (stall),
        .busy      (busy)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] wr,
                                input logic [31:0] wd, input logic se, input logic [31:0] sd,
                                input logic ie, input logic [4:0] ir, input logic [4:0] ra,
                                input logic [4:0] rb, input logic [31:0] ea, input logic [31:0] eb,
                                input logic es, input logic [31:0] ebusy);
        vec_t v;
        v.rst = rst; v.wb_en = we; v.wb_reg = wr; v.wb_data = wd;
        v.st_en = se; v.st_data = sd; v.issue_en = ie; v.issue_reg = ir;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.es = es; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: pop the oldest expectation and compare against live outputs.
    task automatic check_outputs();
        logic [EW-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL exp_q_empty: got 0 entries expected 1");
            return;
        end
        n_checks--;
        e = exp_q.pop_front();
        cmp("data_a", data_a, e[EW-1 -: DW]);
        cmp("data_b", data_b, e[EW-DW-1 -: DW]);
        cmp("stall", {31'd0, stall}, {31'd0, e[32]});
        cmp("busy", busy, e[31:0]);
    endtask

    // Driver: inputs change just after the rising edge, outputs sampled at the falling edge.
    task automatic drive(input vec_t v);
        @(posedge clock);
        #1;
        reset_n   = v.rst;
        wb_en     = v.wb_en;
        wb_reg    = v.wb_reg;
        wb_data   = v.wb_data;
        st_en     = v.st_en;
        st_data   = v.st_data;
        issue_en  = v.issue_en;
        issue_reg = v.issue_reg;
        read_a    = v.ra;
        read_b    = v.rb;
        exp_q.push_back({v.ea, v.eb, v.es, v.ebusy});
        @(negedge clock);
        check_outputs();
    endtask

    initial begin
        vec_t v;
        logic [4:0] wr, rb;
        logic [31:0] wd, eb;

        reset_n = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_data = '0; st_en = 1'b0;
        st_data = '0; issue_en = 1'b0; issue_reg = '0; read_a = '0; read_b = '0;
        repeat (3) @(posedge clock);

        //              rst we wr     wd            se sd        ie ir     ra     rb     ea            eb            es busy
        vecs[0]  = mk(0, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd5,  5'd30, 32'h0,        32'h0,        0, 32'h0);
        vecs[1]  = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd5,  5'd30, 32'h0,        32'h0,        0, 32'h0);
        vecs[2]  = mk(1, 1, 5'd7,  32'hDEADBEEF, 0, 32'h0,    0, 5'd0,  5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        0, 32'h0);
        vecs[3]  = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0);
        vecs[4]  = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    1, 5'd3,  5'd0,  5'd0,  32'h0,        32'h0,        0, 32'h0);
        vecs[5]  = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    1, 5'd5,  5'd0,  5'd3,  32'h0,        32'h0,        1, 32'h8);
        vecs[6]  = mk(1, 1, 5'd3,  32'h12,       0, 32'h0,    0, 5'd0,  5'd5,  5'd3,  32'h0,        32'h12,       0, 32'h8);
        vecs[7]  = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd3,  5'd5,  32'h12,       32'h0,        0, 32'h0);
        vecs[8]  = mk(1, 1, 5'd30, 32'h1,        1, 32'h2A,   0, 5'd0,  5'd30, 5'd7,  32'h2A,       32'hDEADBEEF, 0, 32'h0);
        vecs[9]  = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd30, 5'd0,  32'h2A,       32'h0,        0, 32'h0);
        vecs[10] = mk(1, 1, 5'd0,  32'hFFFF,     0, 32'h0,    1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        0, 32'h0);
        vecs[11] = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        0, 32'h0);
        vecs[12] = mk(1, 1, 5'd4,  32'h44,       0, 32'h0,    1, 5'd4,  5'd4,  5'd0,  32'h44,       32'h0,        0, 32'h0);
        vecs[13] = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    1, 5'd9,  5'd4,  5'd4,  32'h44,       32'h44,       1, 32'h10);
        vecs[14] = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    1, 5'd30, 5'd9,  5'd1,  32'h0,        32'h0,        0, 32'h10);
        vecs[15] = mk(1, 0, 5'd0,  32'h0,        1, 32'h55,   1, 5'd30, 5'd30, 5'd0,  32'h55,       32'h0,        0, 32'h4000_0010);
        vecs[16] = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd30, 5'd4,  32'h55,       32'h44,       1, 32'h4000_0010);
        vecs[17] = mk(1, 1, 5'd4,  32'h99,       1, 32'h66,   0, 5'd0,  5'd4,  5'd30, 32'h99,       32'h66,       0, 32'h4000_0010);
        vecs[18] = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd4,  5'd30, 32'h99,       32'h66,       0, 32'h0);
        vecs[19] = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    1, 5'd12, 5'd12, 5'd0,  32'h0,        32'h0,        0, 32'h0);
        vecs[20] = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd12, 5'd0,  32'h0,        32'h0,        1, 32'h1000);
        vecs[21] = mk(0, 1, 5'd7,  32'h77,       1, 32'hAB,   1, 5'd5,  5'd7,  5'd30, 32'h77,       32'hAB,       0, 32'h0);
        vecs[22] = mk(0, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd7,  5'd4,  32'h0,        32'h0,        0, 32'h0);
        vecs[23] = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    1, 5'd12, 5'd5,  5'd12, 32'h0,        32'h0,        0, 32'h0);
        vecs[24] = mk(1, 0, 5'd0,  32'h0,        0, 32'h0,    0, 5'd0,  5'd12, 5'd30, 32'h0,        32'h0,        1, 32'h1000);
        vecs[25] = mk(1, 1, 5'd12, 32'h1212,     0, 32'h0,    0, 5'd0,  5'd12, 5'd30, 32'h1212,     32'h0,        0, 32'h1000);

        for (int i = 0; i < NV; i++)
            drive(vecs[i]);

        // Random writeback traffic, each write read back through the bypass and
        // a second random port read checked against the memory model.
        for (int i = 0; i < 32; i++)
            model[i] = '0;
        model[12] = 32'h1212;
        for (int i = 0; i < 40; i++) begin
            wr = 5'($urandom_range(1, 31));
            wd = $urandom;
            rb = 5'($urandom_range(0, 31));
            if (rb == 5'd0)
                eb = '0;
            else if (rb == wr)
                eb = wd;
            else
                eb = model[rb];
            v = mk(1, 1, wr, wd, 0, 32'h0, 0, 5'd0, wr, rb, wd, eb, 0, 32'h0);
            drive(v);
            model[wr] = wd;
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL exp_q_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
